// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the mem_sp_bank memory.
//   mem_state_e : sweep controller state (ST_CLEAR, ST_READY)
//   RDW_OLD/NEW : same-address read-during-write policy selectors
//   byte_merge  : lane-wise merge of a new word into an old word
package mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Widest word the merge helper handles; callers zero-extend into it and
  // truncate the result back to their own word width.
  localparam int MERGE_MAX_W = 256;

  // Bit b of the result comes from new_word when the enable of the lane
  // containing b is set, otherwise from old_word.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] be,
    input int                     byte_len
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MERGE_MAX_W; b++) begin
      if (be[b / byte_len]) res[b] = new_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// mem_clear_fsm: zeroing sweep controller for mem_sp_bank.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the sweep from address 0
//   ready      : high once the sweep has finished (accesses accepted)
//   clr_we     : sweep write enable (one word per cycle while clearing)
//   clr_addr   : sweep write address
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing word cnt_q this cycle; ready low
// ST_READY | array initialised; user accesses accepted
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int ADDR_LEN = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                ready,
  output logic                clr_we,
  output logic [ADDR_LEN-1:0] clr_addr
);

  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(MEM_SIZE - 1);

  mem_state_e          state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ready is decoded straight from the state register, so the edge that
  // writes the last word is the edge that raises ready.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: begin
        ready = 1'b1;
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_sp_bank.sv
// mem_sp_bank: one-write/one-read memory with byte enables, self-clearing
// sweep, configurable read latency and read-during-write policy.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   clr              : request a full zeroing sweep (also clears err)
//   ready            : accesses accepted only while high
//   w_en/w_addr/w_be/w_data : write port, per-lane enables
//   r_en/r_addr      : read request
//   r_data/r_valid   : read result, r_data holds between reads
//   err              : sticky out-of-range access flag
module mem_sp_bank
  import mem_pkg::*;
#(
  parameter int ADDR_LEN   = 8,
  parameter int WORD_LEN   = 32,
  parameter int BYTE_LEN   = 8,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  localparam int NBYTES    = WORD_LEN / BYTE_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                ready,
  input  logic                w_en,
  input  logic [ADDR_LEN-1:0] w_addr,
  input  logic [NBYTES-1:0]   w_be,
  input  logic [WORD_LEN-1:0] w_data,
  input  logic                r_en,
  input  logic [ADDR_LEN-1:0] r_addr,
  output logic [WORD_LEN-1:0] r_data,
  output logic                r_valid,
  output logic                err
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_LEN:0] SIZE_X = (ADDR_LEN+1)'(MEM_SIZE);

  logic [WORD_LEN-1:0] mem [MEM_SIZE];

  logic                clr_we;
  logic [ADDR_LEN-1:0] clr_addr;

  logic                w_acc, r_acc;
  logic                w_in, r_in;
  logic [IDX_W-1:0]    w_idx, r_idx;
  logic [WORD_LEN-1:0] w_merged;
  logic [WORD_LEN-1:0] rd_old, rd_word;
  logic                out_v;
  logic [WORD_LEN-1:0] out_d;

  mem_clear_fsm #(
    .ADDR_LEN (ADDR_LEN),
    .MEM_SIZE (MEM_SIZE)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign w_acc = ready & w_en;
  assign r_acc = ready & r_en;
  assign w_in  = ({1'b0, w_addr} < SIZE_X);
  assign r_in  = ({1'b0, r_addr} < SIZE_X);
  assign w_idx = w_addr[IDX_W-1:0];
  assign r_idx = r_addr[IDX_W-1:0];

  assign w_merged = WORD_LEN'(byte_merge(MERGE_MAX_W'(mem[w_idx]),
                                         MERGE_MAX_W'(w_data),
                                         MERGE_MAX_W'(w_be),
                                         BYTE_LEN));

  // Sweep writes take priority; user writes cannot collide with them since
  // they are only accepted while ready is high.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr[IDX_W-1:0]] <= '0;
    end else if (w_acc && w_in) begin
      mem[w_idx] <= w_merged;
    end
  end

  // Out-of-range reads return zero; a same-address write in the same cycle
  // forwards the merged word only under the new-data policy.
  always_comb begin
    rd_old  = r_in ? mem[r_idx] : '0;
    rd_word = rd_old;
    if ((RDW_MODE != RDW_OLD) && w_acc && w_in && r_in && (w_addr == r_addr)) begin
      rd_word = w_merged;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                p_valid;
      logic [WORD_LEN-1:0] p_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_valid <= 1'b0;
          p_data  <= '0;
        end else begin
          p_valid <= r_acc;
          if (r_acc) p_data <= rd_word;
        end
      end

      assign out_v = p_valid;
      assign out_d = p_data;
    end else begin : g_lat1
      assign out_v = r_acc;
      assign out_d = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= out_v;
      if (out_v) r_data <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if ((w_acc && !w_in) || (r_acc && !r_in)) begin
      err <= 1'b1;
    end
  end

endmodule
